// File: rtl/usb3_ep_arbiter.sv
// Endpoint access arbiter for the USB3 link layer: picks the endpoint that sel_endp
// points at (round-robin, optional EP0 priority) and holds it until done/abort/timeout.
module usb3_ep_arbiter #(
   parameter int NUM_EP       = 3,
   parameter int EP0_PRIORITY = 1,
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic              local_clk,
   input  logic              reset_n,
   input  logic [NUM_EP-1:0] ep_req,
   input  logic              xfer_start,
   input  logic              xfer_done,
   input  logic              xfer_abort,
   output logic [3:0]        sel_endp,
   output logic              sel_valid,
   output logic [NUM_EP-1:0] grant,
   output logic              busy,
   output logic              err_timeout
);

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_OFFER   = 2'd1;
   localparam logic [1:0]  S_ACTIVE  = 2'd2;
   localparam logic [1:0]  S_RELEASE = 2'd3;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [3:0]  PTR_RST = 4'(NUM_EP - 1);
   localparam logic [4:0]  NUM_EP5 = 5'(NUM_EP);

   logic [1:0]  state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   logic [15:0] req_pad;
   logic [4:0]  scan_idx;
   logic [3:0]  winner;
   logic [15:0] cnt_inc;
   logic        timeout_hit;

   // Scan downward so the last hit written is the nearest one after the pointer.
   always_comb begin
      req_pad = '0;
      req_pad[NUM_EP-1:0] = ep_req;
      winner   = '0;
      scan_idx = '0;
      for (int k = NUM_EP; k >= 1; k--) begin
         scan_idx = {1'b0, ptr_q} + 5'(k);
         if (scan_idx >= NUM_EP5) scan_idx = scan_idx - NUM_EP5;
         if (req_pad[scan_idx[3:0]]) winner = scan_idx[3:0];
      end
      if ((EP0_PRIORITY != 0) && ep_req[0]) winner = '0;
   end

   assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign timeout_hit = (cnt_q >= TO_LAST);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (|ep_req) begin
               sel_d   = winner;
               state_d = S_OFFER;
            end
         end
         S_OFFER: begin
            cnt_d = cnt_inc;
            if (xfer_start) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end else if (!req_pad[sel_q]) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (timeout_hit) begin
               state_d = S_RELEASE;
               ptr_d   = sel_q;
               err_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         S_ACTIVE: begin
            cnt_d = cnt_inc;
            if (xfer_done) begin
               state_d = S_RELEASE;
               ptr_d   = sel_q;
               cnt_d   = '0;
            end else if (xfer_abort) begin
               // Pointer stays put so the aborted endpoint is retried first.
               state_d = S_RELEASE;
               cnt_d   = '0;
            end else if (timeout_hit) begin
               state_d = S_RELEASE;
               ptr_d   = sel_q;
               err_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge local_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         ptr_q   <= PTR_RST;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign sel_endp    = sel_q;
   assign sel_valid   = (state_q == S_OFFER) || (state_q == S_ACTIVE);
   assign busy        = (state_q == S_ACTIVE);
   assign err_timeout = err_q;

   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_EP; i++) grant[i] = sel_valid && (sel_q == 4'(i));
   end

endmodule

// File: tb/tb_usb3_ep_arbiter.sv
// Directed bench for usb3_ep_arbiter: round-robin order, EP0 priority, abort retry,
// timeout release, offer withdrawal, async reset and done/abort collision.
module tb_usb3_ep_arbiter;

   logic       local_clk;
   logic       reset_n;
   logic [2:0] ep_req;
   logic       xfer_start;
   logic       xfer_done;
   logic       xfer_abort;
   logic [3:0] sel_endp;
   logic       sel_valid;
   logic [2:0] grant;
   logic       busy;
   logic       err_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   usb3_ep_arbiter #(
      .NUM_EP(3),
      .EP0_PRIORITY(1),
      .TIMEOUT_CYC(16)
   ) dut (
      .local_clk(local_clk),
      .reset_n(reset_n),
      .ep_req(ep_req),
      .xfer_start(xfer_start),
      .xfer_done(xfer_done),
      .xfer_abort(xfer_abort),
      .sel_endp(sel_endp),
      .sel_valid(sel_valid),
      .grant(grant),
      .busy(busy),
      .err_timeout(err_timeout)
   );

   // Clock and reset
   initial begin
      local_clk = 1'b0;
      forever #5 local_clk = ~local_clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish before 100000");
      $fatal(1);
   end

   // Driver tasks (no checking inside)
   task automatic tick();
      @(posedge local_clk);
      #1;
   endtask

   task automatic pulse_start();
      xfer_start = 1'b1;
      tick();
      xfer_start = 1'b0;
   endtask

   // From OFFER: start, complete, then land in the IDLE cycle.
   task automatic serve();
      pulse_start();
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ep_req = '0; xfer_start = 0; xfer_done = 0; xfer_abort = 0;
      repeat (3) @(posedge local_clk);
      #2;
      if ({sel_valid, busy, err_timeout} !== 3'b000) begin $display("FAIL reset_flags: got %b want 000", {sel_valid, busy, err_timeout}); n_fail++; end
      n_tests++;
      if (sel_endp !== 4'd0) begin $display("FAIL reset_sel: got %0d want 0", sel_endp); n_fail++; end
      n_tests++;
      if (grant !== 3'b000) begin $display("FAIL reset_grant: got %b want 000", grant); n_fail++; end
      n_tests++;
      reset_n = 1'b1;
      tick();
      if (sel_valid !== 1'b0) begin $display("FAIL idle_no_req: got %b want 0", sel_valid); n_fail++; end
      n_tests++;
   endtask

   task automatic test_round_robin();
      ep_req = 3'b110;
      tick();
      if ({sel_valid, sel_endp} !== {1'b1, 4'd1}) begin $display("FAIL rr_first: got v=%b sel=%0d want v=1 sel=1", sel_valid, sel_endp); n_fail++; end
      n_tests++;
      if (grant !== 3'b010) begin $display("FAIL rr_first_grant: got %b want 010", grant); n_fail++; end
      n_tests++;
      tick();
      pulse_start();
      if (busy !== 1'b1) begin $display("FAIL rr_active: got busy=%b want 1", busy); n_fail++; end
      n_tests++;
      repeat (4) tick();
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      if ({sel_valid, busy, grant} !== 5'b0) begin $display("FAIL rr_release: got v=%b b=%b g=%b want 0 0 000", sel_valid, busy, grant); n_fail++; end
      n_tests++;
      tick();
      if (sel_valid !== 1'b0) begin $display("FAIL rr_idle_gap: got %b want 0", sel_valid); n_fail++; end
      n_tests++;
      tick();
      if ({sel_valid, sel_endp} !== {1'b1, 4'd2}) begin $display("FAIL rr_second: got v=%b sel=%0d want v=1 sel=2", sel_valid, sel_endp); n_fail++; end
      n_tests++;
      serve();
      tick();
      if (sel_endp !== 4'd1) begin $display("FAIL rr_third: got %0d want 1", sel_endp); n_fail++; end
      n_tests++;
      serve();
      ep_req = '0;
   endtask

   task automatic test_ep0_priority();
      ep_req = 3'b010;
      tick();
      if (sel_endp !== 4'd1) begin $display("FAIL prio_setup: got %0d want 1", sel_endp); n_fail++; end
      n_tests++;
      pulse_start();
      ep_req = 3'b111;
      repeat (3) tick();
      if ({busy, sel_endp, grant} !== {1'b1, 4'd1, 3'b010}) begin $display("FAIL prio_hold: got b=%b sel=%0d g=%b want 1 1 010", busy, sel_endp, grant); n_fail++; end
      n_tests++;
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      tick();
      tick();
      if ({sel_valid, sel_endp} !== {1'b1, 4'd0}) begin $display("FAIL prio_ep0: got v=%b sel=%0d want v=1 sel=0", sel_valid, sel_endp); n_fail++; end
      n_tests++;
      serve();
      ep_req = '0;
   endtask

   task automatic test_abort_retry();
      ep_req = 3'b110;
      tick();
      serve();
      tick();
      if (sel_endp !== 4'd2) begin $display("FAIL abort_setup: got %0d want 2", sel_endp); n_fail++; end
      n_tests++;
      pulse_start();
      xfer_abort = 1'b1;
      tick();
      xfer_abort = 1'b0;
      if ({sel_valid, err_timeout} !== 2'b00) begin $display("FAIL abort_release: got v=%b e=%b want 0 0", sel_valid, err_timeout); n_fail++; end
      n_tests++;
      tick();
      tick();
      if (sel_endp !== 4'd2) begin $display("FAIL abort_retry: got %0d want 2", sel_endp); n_fail++; end
      n_tests++;
      serve();
      tick();
      if (sel_endp !== 4'd1) begin $display("FAIL abort_after_done: got %0d want 1", sel_endp); n_fail++; end
      n_tests++;
      serve();
      ep_req = '0;
   endtask

   task automatic test_timeout();
      ep_req = 3'b010;
      tick();
      if (sel_endp !== 4'd1) begin $display("FAIL to_setup: got %0d want 1", sel_endp); n_fail++; end
      n_tests++;
      pulse_start();
      ep_req = 3'b110;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if ({err_timeout, busy} !== 2'b01) begin $display("FAIL to_early_c%0d: got e=%b b=%b want 0 1", i, err_timeout, busy); n_fail++; end
         n_tests++;
      end
      tick();
      if ({err_timeout, sel_valid} !== 2'b10) begin $display("FAIL to_fire: got e=%b v=%b want 1 0", err_timeout, sel_valid); n_fail++; end
      n_tests++;
      tick();
      if (err_timeout !== 1'b0) begin $display("FAIL to_one_cycle: got %b want 0", err_timeout); n_fail++; end
      n_tests++;
      tick();
      if ({sel_valid, sel_endp} !== {1'b1, 4'd2}) begin $display("FAIL to_next: got v=%b sel=%0d want v=1 sel=2", sel_valid, sel_endp); n_fail++; end
      n_tests++;
      ep_req = '0;
      tick();
   endtask

   task automatic test_offer_withdraw();
      ep_req = 3'b100;
      tick();
      if (sel_endp !== 4'd2) begin $display("FAIL wd_setup: got %0d want 2", sel_endp); n_fail++; end
      n_tests++;
      ep_req = '0;
      tick();
      if ({sel_valid, err_timeout, sel_endp} !== {2'b00, 4'd2}) begin $display("FAIL wd_drop: got v=%b e=%b sel=%0d want 0 0 2", sel_valid, err_timeout, sel_endp); n_fail++; end
      n_tests++;
      ep_req = 3'b100;
      tick();
      ep_req = '0;
      xfer_start = 1'b1;
      tick();
      xfer_start = 1'b0;
      if ({busy, sel_valid, sel_endp} !== {2'b11, 4'd2}) begin $display("FAIL wd_start_wins: got b=%b v=%b sel=%0d want 1 1 2", busy, sel_valid, sel_endp); n_fail++; end
      n_tests++;
      tick();
      if (busy !== 1'b1) begin $display("FAIL wd_no_revoke: got %b want 1", busy); n_fail++; end
      n_tests++;
   endtask

   task automatic test_async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      if ({sel_valid, busy, grant, sel_endp} !== 9'b0) begin $display("FAIL areset_clear: got v=%b b=%b g=%b sel=%0d want all 0", sel_valid, busy, grant, sel_endp); n_fail++; end
      n_tests++;
      ep_req = 3'b001;
      #2;
      reset_n = 1'b1;
      tick();
      if ({sel_valid, sel_endp, grant} !== {1'b1, 4'd0, 3'b001}) begin $display("FAIL areset_offer: got v=%b sel=%0d g=%b want 1 0 001", sel_valid, sel_endp, grant); n_fail++; end
      n_tests++;
   endtask

   task automatic test_done_abort_same_cycle();
      ep_req = '0;
      tick();
      if (sel_valid !== 1'b0) begin $display("FAIL da_withdraw: got %b want 0", sel_valid); n_fail++; end
      n_tests++;
      ep_req = 3'b110;
      tick();
      if (sel_endp !== 4'd1) begin $display("FAIL da_setup: got %0d want 1", sel_endp); n_fail++; end
      n_tests++;
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      if ({sel_valid, busy} !== 2'b10) begin $display("FAIL da_done_in_offer: got v=%b b=%b want 1 0", sel_valid, busy); n_fail++; end
      n_tests++;
      pulse_start();
      xfer_done  = 1'b1;
      xfer_abort = 1'b1;
      tick();
      xfer_done  = 1'b0;
      xfer_abort = 1'b0;
      tick();
      tick();
      if (sel_endp !== 4'd2) begin $display("FAIL da_done_wins: got %0d want 2", sel_endp); n_fail++; end
      n_tests++;
      ep_req = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_ep0_priority();
      test_abort_retry();
      test_timeout();
      test_offer_withdraw();
      test_async_reset();
      test_done_abort_same_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/usb3_ep_arbiter.md
Name: usb3_ep_arbiter

Overview:
- Schedules link-layer access to the per-endpoint buffer ports. It chooses which endpoint the link layer's sel_endp mux points at, then holds that choice until the transaction completes, is aborted, or times out.
- Sits between the endpoint buffers (hasdata / ready flags) and the link layer's transaction engine. It feeds sel_endp to the protocol-layer mux.
- Arbitration is round-robin, with optional strict priority for EP0 (control traffic).

Parameters:
- NUM_EP, 3, number of endpoints arbitrated (1..16). Index i maps to sel_endp value i.
- EP0_PRIORITY, 1, 1 = EP0 always wins when requesting; 0 = EP0 takes part in round-robin like any other endpoint.
- TIMEOUT_CYC, 4096, local_clk cycles allowed in OFFER or ACTIVE before forced release (1..65535).

Ports:
- local_clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ep_req  in  NUM_EP  per-endpoint service request (level).
- xfer_start  in  1  link layer has begun a transaction on the offered endpoint (pulse).
- xfer_done  in  1  transaction complete, i.e. commit_ack or arm_ack seen (pulse).
- xfer_abort  in  1  link layer abandoned the transaction, e.g. NRDY or link error (pulse).
- sel_endp  out  4  selected endpoint number.
- sel_valid  out  1  sel_endp is an active offer or grant.
- grant  out  NUM_EP  one-hot copy of sel_endp, qualified by sel_valid.
- busy  out  1  high in the ACTIVE state.
- err_timeout  out  1  one-cycle pulse on a timeout release.

Behaviour:
Reset (async assert, sync-free release):
- All outputs reset to 0.
- State = IDLE, last-served pointer = NUM_EP-1, timeout counter = 0.
- Reset asserted mid-transaction clears everything immediately; no done or abort is reported.

State IDLE:
- sel_valid=0; sel_endp holds its last value so the downstream mux stays stable.
- If ep_req != 0, the winner is computed combinationally and registered, and the state moves to OFFER.
- sel_valid=1 from the next edge, so latency from a sampled ep_req to sel_valid is 1 cycle.
- Winner rule:
  - If EP0_PRIORITY=1 and ep_req[0], the winner is 0.
  - Otherwise the winner is the first set bit scanning upward from pointer+1, wrapping modulo NUM_EP.

State OFFER:
- sel_valid=1; the timeout counter increments each cycle.
- xfer_start → ACTIVE; the counter is cleared.
- ep_req[sel] drops with no xfer_start in the same cycle → IDLE (offer withdrawn). The pointer is unchanged.
- Counter reaches TIMEOUT_CYC-1 → RELEASE with err_timeout pulse.
- xfer_start and a req drop in the same cycle: start wins.
- xfer_done or xfer_abort arriving in OFFER is ignored.

State ACTIVE:
- sel_valid=1, busy=1; the counter increments each cycle. ep_req is ignored, so a grant is never revoked by req changes.
- xfer_done → RELEASE; pointer := sel.
- xfer_abort → RELEASE; pointer is unchanged, so the same endpoint is retried first next round unless EP0 preempts.
- done and abort in the same cycle: done wins.
- Counter reaches TIMEOUT_CYC-1 → RELEASE; pointer := sel; err_timeout=1 for exactly one cycle.
- A further xfer_start in ACTIVE is ignored.

State RELEASE:
- Exactly one cycle with sel_valid=0, grant=0, busy=0, then IDLE.
- Guarantees a minimum 1-cycle gap between grants, so the mux can settle.

Arithmetic and widths:
- Counter is 16 bits and saturates; it never wraps.
- Pointer is 4 bits; wrap compare is against NUM_EP-1.
- With NUM_EP=1, round-robin degenerates to always selecting 0.

Invariants:
- grant is one-hot or zero.
- grant != 0 iff sel_valid.
- sel_endp < NUM_EP always.

Test Plan:
1. Reset, then ep_req=3'b110 held, xfer_start 2 cycles after sel_valid, xfer_done 5 cycles later; repeat.
   - sel_endp=1, then 2, then 1.
   - Each sel_valid rises 1 cycle after IDLE samples the req.
   - 1-cycle sel_valid=0 gap between grants.
2. EP0_PRIORITY=1: EP1 ACTIVE, ep_req[0] rises mid-transfer.
   - EP1 keeps the grant until xfer_done.
   - Next grant is sel_endp=0, even though EP2 is also requesting.
3. xfer_abort on EP2 with ep_req=3'b110.
   - Next grant is sel_endp=2 again (pointer not advanced).
   - After xfer_done, the next grant is 1.
4. TIMEOUT_CYC=16, grant EP1, xfer_start, then no done.
   - err_timeout high for exactly 1 cycle, 16 cycles after xfer_start.
   - sel_valid drops; the next grant goes to another requester.
5. Offer withdrawal: EP2 offered, ep_req[2] dropped before xfer_start.
   - sel_valid falls the next cycle; no err_timeout.
   - Same cycle as the drop with xfer_start=1: the state enters ACTIVE instead.
6. Assert reset_n=0 asynchronously while ACTIVE.
   - sel_valid, busy, grant and sel_endp go to 0 without a clock edge.
   - After release with ep_req=3'b001, sel_endp=0 is offered 1 cycle after the first sampled edge.
